// File: rtl/ama_riscv_perf_pkg.sv
// Shared types and defaults for the performance counter block.
// Optional STALL/FLUSH event counters are enabled by PERF_EVT_CNT_EN.
package ama_riscv_perf_pkg;

    localparam int PERF_CNT_W  = 64;
    localparam int PERF_EVT_W  = 32;
    localparam int PERF_ADDR_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FROZEN = 2'd2
    } perf_state_t;

    typedef enum logic [3:0] {
        ADDR_CYCLE_LO   = 4'd0,
        ADDR_CYCLE_HI   = 4'd1,
        ADDR_INSTRET_LO = 4'd2,
        ADDR_INSTRET_HI = 4'd3,
        ADDR_STALL      = 4'd4,
        ADDR_FLUSH      = 4'd5,
        ADDR_STATUS     = 4'd6
    } perf_addr_t;

    localparam int STATUS_RUNNING_BIT = 0;
    localparam int STATUS_FROZEN_BIT  = 1;

endpackage

// File: rtl/ama_riscv_perf_ctr.sv
// Clearable event counter; wraps by default, sticks at all-ones when SATURATE=1.
// Clear has priority over increment.
module ama_riscv_perf_ctr #(
    parameter int W        = 64,
    parameter bit SATURATE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic         at_max;

    assign at_max = &cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && !(SATURATE && at_max)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/ama_riscv_perf_cnt.sv
// Cycle/instret performance counters with IDLE/RUN/FROZEN control and a 1-cycle MMIO read port.
// PERF_EVT_CNT_EN adds saturating STALL and FLUSH counters at word 4/5 (read 0 otherwise).
module ama_riscv_perf_cnt
    import ama_riscv_perf_pkg::*;
#(
    parameter int CNT_W  = PERF_CNT_W,
    parameter int EVT_W  = PERF_EVT_W,
    parameter int ADDR_W = PERF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inst_wb_nop_or_clear,
    input  logic              stall_id,
    input  logic              flush_ex,
    input  logic              tohost_we,
    input  logic              mmio_reset_cnt,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    output logic              rd_valid,
    output logic              cnt_running
);

    perf_state_t      state_q;
    logic             retire;
    logic             count_en;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] instret_cnt;
    logic [31:0]      cyc_shadow_q;
    logic [31:0]      ins_shadow_q;
    logic [31:0]      status;
    logic [31:0]      rd_data_d;
    logic [31:0]      rd_data_q;
    logic             rd_valid_q;

    assign retire = !inst_wb_nop_or_clear;

    // The IDLE->RUN transition cycle is itself counted.
    assign count_en = !mmio_reset_cnt &&
                      ((state_q == RUN) || ((state_q == IDLE) && retire));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else if (mmio_reset_cnt) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (retire)    state_q <= RUN;
                RUN:     if (tohost_we) state_q <= FROZEN;
                FROZEN:  state_q <= FROZEN;
                default: state_q <= IDLE;
            endcase
        end
    end

    ama_riscv_perf_ctr #(.W(CNT_W), .SATURATE(1'b0)) u_cycle (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mmio_reset_cnt),
        .inc   (count_en),
        .cnt   (cycle_cnt)
    );

    ama_riscv_perf_ctr #(.W(CNT_W), .SATURATE(1'b0)) u_instret (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mmio_reset_cnt),
        .inc   (count_en && retire),
        .cnt   (instret_cnt)
    );

`ifdef PERF_EVT_CNT_EN
    logic [EVT_W-1:0] stall_cnt;
    logic [EVT_W-1:0] flush_cnt;

    ama_riscv_perf_ctr #(.W(EVT_W), .SATURATE(1'b1)) u_stall (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mmio_reset_cnt),
        .inc   (count_en && stall_id),
        .cnt   (stall_cnt)
    );

    ama_riscv_perf_ctr #(.W(EVT_W), .SATURATE(1'b1)) u_flush (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (mmio_reset_cnt),
        .inc   (count_en && flush_ex),
        .cnt   (flush_cnt)
    );
`else
    logic unused_evt;
    assign unused_evt = stall_id ^ flush_ex ^ (EVT_W == 0);
`endif

    // Reading a LO word snapshots the upper half so the following HI read is coherent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_shadow_q <= '0;
            ins_shadow_q <= '0;
        end else if (mmio_reset_cnt) begin
            cyc_shadow_q <= '0;
            ins_shadow_q <= '0;
        end else if (rd_en) begin
            if (rd_addr == ADDR_W'(ADDR_CYCLE_LO))
                cyc_shadow_q <= 32'(cycle_cnt >> 32);
            if (rd_addr == ADDR_W'(ADDR_INSTRET_LO))
                ins_shadow_q <= 32'(instret_cnt >> 32);
        end
    end

    always_comb begin
        status                     = '0;
        status[STATUS_RUNNING_BIT] = (state_q == RUN);
        status[STATUS_FROZEN_BIT]  = (state_q == FROZEN);
    end

    always_comb begin
        rd_data_d = '0;
        case (rd_addr)
            ADDR_W'(ADDR_CYCLE_LO):   rd_data_d = cycle_cnt[31:0];
            ADDR_W'(ADDR_CYCLE_HI):   rd_data_d = cyc_shadow_q;
            ADDR_W'(ADDR_INSTRET_LO): rd_data_d = instret_cnt[31:0];
            ADDR_W'(ADDR_INSTRET_HI): rd_data_d = ins_shadow_q;
`ifdef PERF_EVT_CNT_EN
            ADDR_W'(ADDR_STALL):      rd_data_d = 32'(stall_cnt);
            ADDR_W'(ADDR_FLUSH):      rd_data_d = 32'(flush_cnt);
`endif
            ADDR_W'(ADDR_STATUS):     rd_data_d = status;
            default:                  rd_data_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en)
                rd_data_q <= rd_data_d;
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign cnt_running = (state_q == RUN);

endmodule

// File: tb/tb_ama_riscv_perf_cnt.sv
// Directed bench for ama_riscv_perf_cnt; define PERF_EVT_CNT_EN to also cover STALL/FLUSH.
module tb_ama_riscv_perf_cnt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_wb_nop_or_clear;
    logic        stall_id;
    logic        flush_ex;
    logic        tohost_we;
    logic        mmio_reset_cnt;
    logic        rd_en;
    logic [3:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        cnt_running;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] rdat;
    logic        rvld;

    always #5 clk = ~clk;

    ama_riscv_perf_cnt u_dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .inst_wb_nop_or_clear (inst_wb_nop_or_clear),
        .stall_id             (stall_id),
        .flush_ex             (flush_ex),
        .tohost_we            (tohost_we),
        .mmio_reset_cnt       (mmio_reset_cnt),
        .rd_en                (rd_en),
        .rd_addr              (rd_addr),
        .rd_data              (rd_data),
        .rd_valid             (rd_valid),
        .cnt_running          (cnt_running)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic do_read(input logic [3:0] addr, output logic [31:0] data, output logic vld);
        rd_en   = 1'b1;
        rd_addr = addr;
        tick(1);
        rd_en   = 1'b0;
        data    = rd_data;
        vld     = rd_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        inst_wb_nop_or_clear = 1'b1;
        stall_id = 1'b0;
        flush_ex = 1'b0;
        tohost_we = 1'b0;
        mmio_reset_cnt = 1'b0;
        rd_en = 1'b0;
        rd_addr = '0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        tests_run++;
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL reset_running: got %b want 0", cnt_running); end
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_idle_then_run();
        tick(10);
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL idle_running: got %b want 0", cnt_running); end
        inst_wb_nop_or_clear = 1'b0;
        tick(5);
        inst_wb_nop_or_clear = 1'b1;
        do_read(4'd0, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd5) begin tests_failed++; $display("FAIL t1_cycle_lo: got %0d want 5", rdat); end
        tests_run++;
        if (rvld !== 1'b1) begin tests_failed++; $display("FAIL t1_rd_valid: got %b want 1", rvld); end
        do_read(4'd2, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd5) begin tests_failed++; $display("FAIL t1_instret_lo: got %0d want 5", rdat); end
        tests_run++;
        if (cnt_running !== 1'b1) begin tests_failed++; $display("FAIL t1_running: got %b want 1", cnt_running); end
        tick(1);
        tests_run++;
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL t1_valid_drop: got %b want 0", rd_valid); end
        tests_run++;
        if (rd_data !== 32'd5) begin tests_failed++; $display("FAIL t1_data_hold: got %0d want 5", rd_data); end
    endtask

    task automatic test_shadow_carry();
        force u_dut.u_cycle.cnt_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release u_dut.u_cycle.cnt_q;
        tick(1);
        do_read(4'd0, rdat, rvld);
        tests_run++;
        if (rdat !== 32'h0) begin tests_failed++; $display("FAIL t2_cycle_lo: got %h want 0", rdat); end
        do_read(4'd1, rdat, rvld);
        tests_run++;
        if (rdat !== 32'h1) begin tests_failed++; $display("FAIL t2_cycle_hi: got %h want 1", rdat); end
    endtask

    task automatic test_tohost_freeze();
        mmio_reset_cnt = 1'b1;
        tick(1);
        mmio_reset_cnt = 1'b0;
        do_read(4'd1, rdat, rvld);
        tests_run++;
        if (rdat !== 32'h0) begin tests_failed++; $display("FAIL t3_shadow_clr: got %h want 0", rdat); end
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL t3_idle_after_clr: got %b want 0", cnt_running); end
        inst_wb_nop_or_clear = 1'b0;
        tick(20);
        tohost_we = 1'b1;
        tick(1);
        tohost_we = 1'b0;
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL t3_frozen_running: got %b want 0", cnt_running); end
        tick(10);
        do_read(4'd2, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd21) begin tests_failed++; $display("FAIL t3_instret: got %0d want 21", rdat); end
        do_read(4'd0, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd21) begin tests_failed++; $display("FAIL t3_cycle: got %0d want 21", rdat); end
        do_read(4'd6, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd2) begin tests_failed++; $display("FAIL t3_status: got %0d want 2", rdat); end
        do_read(4'd3, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd0) begin tests_failed++; $display("FAIL t3_instret_hi: got %0d want 0", rdat); end
        do_read(4'd9, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd0) begin tests_failed++; $display("FAIL t3_unmapped: got %h want 0", rdat); end
    endtask

    task automatic test_reset_cnt_read();
        inst_wb_nop_or_clear = 1'b0;
        mmio_reset_cnt = 1'b1;
        rd_en = 1'b1;
        rd_addr = 4'd0;
        tick(1);
        mmio_reset_cnt = 1'b0;
        rd_en = 1'b0;
        inst_wb_nop_or_clear = 1'b1;
        tests_run++;
        if (rd_data !== 32'd21) begin tests_failed++; $display("FAIL t4_pre_clear: got %0d want 21", rd_data); end
        tests_run++;
        if (rd_valid !== 1'b1) begin tests_failed++; $display("FAIL t4_valid: got %b want 1", rd_valid); end
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL t4_running: got %b want 0", cnt_running); end
        do_read(4'd0, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd0) begin tests_failed++; $display("FAIL t4_cycle_cleared: got %0d want 0", rdat); end
        do_read(4'd2, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd0) begin tests_failed++; $display("FAIL t4_instret_cleared: got %0d want 0", rdat); end
        do_read(4'd6, rdat, rvld);
        tests_run++;
        if (rdat !== 32'd0) begin tests_failed++; $display("FAIL t4_status_idle: got %0d want 0", rdat); end
    endtask

    task automatic test_evt_cnt();
        logic [31:0] exp_stall;
        logic [31:0] exp_flush;
        logic [31:0] exp_sat;
`ifdef PERF_EVT_CNT_EN
        exp_stall = 32'd7;
        exp_flush = 32'd3;
        exp_sat   = 32'hFFFF_FFFF;
`else
        exp_stall = 32'd0;
        exp_flush = 32'd0;
        exp_sat   = 32'd0;
`endif
        // Stalls while IDLE must not count.
        stall_id = 1'b1;
        tick(2);
        inst_wb_nop_or_clear = 1'b0;
        flush_ex = 1'b1;
        tick(3);
        flush_ex = 1'b0;
        tick(4);
        stall_id = 1'b0;
        inst_wb_nop_or_clear = 1'b1;
        do_read(4'd4, rdat, rvld);
        tests_run++;
        if (rdat !== exp_stall) begin tests_failed++; $display("FAIL t5_stall: got %0d want %0d", rdat, exp_stall); end
        do_read(4'd5, rdat, rvld);
        tests_run++;
        if (rdat !== exp_flush) begin tests_failed++; $display("FAIL t5_flush: got %0d want %0d", rdat, exp_flush); end
`ifdef PERF_EVT_CNT_EN
        force u_dut.u_stall.cnt_q = 32'hFFFF_FFFF;
        #1;
        release u_dut.u_stall.cnt_q;
`endif
        stall_id = 1'b1;
        tick(1);
        stall_id = 1'b0;
        do_read(4'd4, rdat, rvld);
        tests_run++;
        if (rdat !== exp_sat) begin tests_failed++; $display("FAIL t5_stall_sat: got %h want %h", rdat, exp_sat); end
    endtask

    task automatic test_async_reset();
        tests_run++;
        if (cnt_running !== 1'b1) begin tests_failed++; $display("FAIL t6_pre_running: got %b want 1", cnt_running); end
        rd_en = 1'b1;
        rd_addr = 4'd0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (rd_data !== 32'h0) begin tests_failed++; $display("FAIL t6_rd_data: got %h want 0", rd_data); end
        tests_run++;
        if (rd_valid !== 1'b0) begin tests_failed++; $display("FAIL t6_rd_valid: got %b want 0", rd_valid); end
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL t6_running: got %b want 0", cnt_running); end
        rd_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        tests_run++;
        if (cnt_running !== 1'b0) begin tests_failed++; $display("FAIL t6_idle_after: got %b want 0", cnt_running); end
        do_read(4'd0, rdat, rvld);
        tests_run++;
        if (rdat !== 32'h0) begin tests_failed++; $display("FAIL t6_cycle_zero: got %h want 0", rdat); end
    endtask

    initial begin
        test_reset();
        test_idle_then_run();
        test_shadow_carry();
        test_tohost_freeze();
        test_reset_cnt_read();
        test_evt_cnt();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
